// File: rtl/cmd_pointer.sv
// ---------------------------------------------------------------------------
// cmd_pointer
//   Command address pointer for the sequencer front end. Holds the current
//   command address and changes it only on an explicit opcode: absolute jump
//   (JMP), short jump forward (SJF) or short jump back (SJB). Each accepted
//   command lowers ready for exactly one cycle while the new address is
//   committed. Fetch logic may read addr_point whenever ready is high.
//
//   Optional build macro: CMD_POINT_SAT_EN
//     defined   : SJF saturates at all-ones, SJB saturates at zero
//     undefined : SJF/SJB wrap modulo 2^BUS_WIDTH
//
// Ports
//   clk         in   1          system clock, rising edge
//   nreset      in   1          asynchronous active-low reset
//   opcode      in   3          one-hot: 000 NUL, 001 JMP, 010 SJF, 100 SJB
//   addr_to     in   BUS_WIDTH  JMP target, or unsigned SJF/SJB offset
//   addr_point  out  BUS_WIDTH  current command address (registered)
//   ready       out  1          pointer stable, new opcode accepted
// ---------------------------------------------------------------------------
module cmd_pointer #(
   parameter int unsigned BUS_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic [2:0]           opcode,
   input  logic [BUS_WIDTH-1:0] addr_to,
   output logic [BUS_WIDTH-1:0] addr_point,
   output logic                 ready
);

   localparam int unsigned OP_W = 3;
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(3'b001);
   localparam logic [OP_W-1:0] OP_SJF = OP_W'(3'b010);
   localparam logic [OP_W-1:0] OP_SJB = OP_W'(3'b100);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UPDATE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [BUS_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WIDTH-1:0] target_q, target_d;
   logic                 ready_q, ready_d;

   logic [BUS_WIDTH-1:0] sjf_target_c;
   logic [BUS_WIDTH-1:0] sjb_target_c;

`ifdef CMD_POINT_SAT_EN
   // Extra MSB captures carry (SJF) or borrow (SJB) for clamping.
   logic                 sjf_carry_c;
   logic                 sjb_borrow_c;
   logic [BUS_WIDTH-1:0] sjf_sum_c;
   logic [BUS_WIDTH-1:0] sjb_diff_c;

   assign {sjf_carry_c, sjf_sum_c}  = {1'b0, addr_q} + {1'b0, addr_to};
   assign {sjb_borrow_c, sjb_diff_c} = {1'b0, addr_q} - {1'b0, addr_to};
   assign sjf_target_c = sjf_carry_c  ? {BUS_WIDTH{1'b1}} : sjf_sum_c;
   assign sjb_target_c = sjb_borrow_c ? {BUS_WIDTH{1'b0}} : sjb_diff_c;
`else
   // Plain modulo arithmetic; carry/borrow are dropped.
   assign sjf_target_c = addr_q + addr_to;
   assign sjb_target_c = addr_q - addr_to;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= ST_INIT;
         addr_q   <= '0;
         target_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         target_q <= target_d;
         ready_q  <= ready_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      target_d = target_q;
      ready_d  = ready_q;

      unique case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end

         ST_IDLE: begin
            // Illegal and NUL opcodes fall through with no state change.
            if (opcode == OP_JMP || opcode == OP_SJF || opcode == OP_SJB) begin
               state_d = ST_UPDATE;
               ready_d = 1'b0;
               if (opcode == OP_JMP) begin
                  target_d = addr_to;
               end else if (opcode == OP_SJF) begin
                  target_d = sjf_target_c;
               end else begin
                  target_d = sjb_target_c;
               end
            end
         end

         ST_UPDATE: begin
            // Opcode is ignored here; the latched target is committed.
            addr_d  = target_q;
            ready_d = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_INIT;
            ready_d = 1'b0;
         end
      endcase
   end

   assign addr_point = addr_q;
   assign ready      = ready_q;

endmodule

// File: tb/tb_cmd_pointer.sv
// ---------------------------------------------------------------------------
// tb_cmd_pointer
//   Self-checking bench for cmd_pointer: directed scenarios followed by
//   randomized opcodes, offsets and occasional resets, compared every cycle
//   against a behavioural model using 64-bit arithmetic.
//   Honours CMD_POINT_SAT_EN for saturation expectations.
// ---------------------------------------------------------------------------
module tb_cmd_pointer;

   localparam int unsigned BW = 32;
   localparam longint unsigned MASK = 64'h0000_0000_FFFF_FFFF;

   logic          clk = 1'b0;
   logic          nreset;
   logic [2:0]    opcode;
   logic [BW-1:0] addr_to;
   logic [BW-1:0] addr_point;
   logic          ready;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: whether the first post-reset edge has happened, whether a
   // command is waiting to be committed, and the visible outputs.
   bit              m_live;
   bit              m_pend;
   longint unsigned m_tgt;
   longint unsigned m_addr;
   bit              m_ready;

   cmd_pointer #(.BUS_WIDTH(BW)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .opcode     (opcode),
      .addr_to    (addr_to),
      .addr_point (addr_point),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_live  = 1'b0;
      m_pend  = 1'b0;
      m_tgt   = 0;
      m_addr  = 0;
      m_ready = 1'b0;
   endtask

   // One rising edge of the reference model, using current inputs.
   task automatic model_edge();
      longint unsigned a;
      a = longint'(addr_to);
      if (!nreset) begin
         m_reset();
      end else if (!m_live) begin
         m_live  = 1'b1;
         m_ready = 1'b1;
      end else if (m_pend) begin
         m_addr  = m_tgt;
         m_pend  = 1'b0;
         m_ready = 1'b1;
      end else if (opcode == 3'b001 || opcode == 3'b010 || opcode == 3'b100) begin
         if (opcode == 3'b001) begin
            m_tgt = a;
         end else if (opcode == 3'b010) begin
`ifdef CMD_POINT_SAT_EN
            m_tgt = (m_addr + a > MASK) ? MASK : m_addr + a;
`else
            m_tgt = (m_addr + a) & MASK;
`endif
         end else begin
`ifdef CMD_POINT_SAT_EN
            m_tgt = (a > m_addr) ? 0 : m_addr - a;
`else
            m_tgt = (m_addr + (MASK + 1) - a) & MASK;
`endif
         end
         m_pend  = 1'b1;
         m_ready = 1'b0;
      end
   endtask

   // Drive inputs at negedge, step model at posedge, check 1 time unit later.
   task automatic cycle(input logic [2:0] op, input logic [BW-1:0] a, input bit rn);
      @(negedge clk);
      opcode  = op;
      addr_to = a;
      nreset  = rn;
      if (!rn) begin
         m_reset();
         #1;
         check_eq("async_rst_addr", 64'(addr_point), 64'd0);
         check_eq("async_rst_ready", 64'(ready), 64'd0);
      end
      @(posedge clk);
      model_edge();
      #1;
      check_eq("addr", 64'(addr_point), m_addr);
      check_eq("ready", 64'(ready), 64'(m_ready));
   endtask

   initial begin
      logic [2:0]    ops [8];
      logic [2:0]    op;
      logic [BW-1:0] a;
      bit            rn;

      ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;
      ops[4] = 3'b011; ops[5] = 3'b101; ops[6] = 3'b110; ops[7] = 3'b111;

      nreset  = 1'b0;
      opcode  = 3'b000;
      addr_to = '0;
      m_reset();
      #1;
      check_eq("reset_addr", 64'(addr_point), 64'd0);
      check_eq("reset_ready", 64'(ready), 64'd0);

      // Reset held for two clocks, then released.
      cycle(3'b000, '0, 1'b0);
      cycle(3'b000, '0, 1'b0);
      check_eq("in_reset_ready", 64'(ready), 64'd0);
      cycle(3'b000, '0, 1'b1);
      check_eq("first_edge_ready", 64'(ready), 64'd1);
      check_eq("first_edge_addr", 64'(addr_point), 64'd0);

      // JMP 0x1234
      cycle(3'b001, 32'h0000_1234, 1'b1);
      check_eq("jmp_ready_low", 64'(ready), 64'd0);
      cycle(3'b000, '0, 1'b1);
      check_eq("jmp_ready_back", 64'(ready), 64'd1);
      check_eq("jmp_addr", 64'(addr_point), 64'h1234);

      // SJF +2, then SJB -2
      cycle(3'b010, 32'd2, 1'b1);
      cycle(3'b000, '0, 1'b1);
      check_eq("sjf_addr", 64'(addr_point), 64'h1236);
      cycle(3'b100, 32'd2, 1'b1);
      cycle(3'b000, '0, 1'b1);
      check_eq("sjb_addr", 64'(addr_point), 64'h1234);

      // Illegal opcode 011: no change, ready stays high
      cycle(3'b011, 32'h55, 1'b1);
      check_eq("illegal_ready", 64'(ready), 64'd1);
      check_eq("illegal_addr", 64'(addr_point), 64'h1234);

      // SJF with zero offset still costs a ready-low cycle
      cycle(3'b010, 32'd0, 1'b1);
      check_eq("sjf0_ready_low", 64'(ready), 64'd0);
      cycle(3'b000, '0, 1'b1);
      check_eq("sjf0_addr", 64'(addr_point), 64'h1234);

      // Underflow from 0
      cycle(3'b001, 32'd0, 1'b1);
      cycle(3'b000, '0, 1'b1);
      cycle(3'b100, 32'd1, 1'b1);
      cycle(3'b000, '0, 1'b1);
`ifdef CMD_POINT_SAT_EN
      check_eq("sjb_under_addr", 64'(addr_point), 64'd0);
`else
      check_eq("sjb_under_addr", 64'(addr_point), 64'hFFFF_FFFF);
`endif

      // Overflow from all-ones
      cycle(3'b001, 32'hFFFF_FFFF, 1'b1);
      cycle(3'b000, '0, 1'b1);
      cycle(3'b010, 32'd3, 1'b1);
      cycle(3'b000, '0, 1'b1);
`ifdef CMD_POINT_SAT_EN
      check_eq("sjf_over_addr", 64'(addr_point), 64'hFFFF_FFFF);
`else
      check_eq("sjf_over_addr", 64'(addr_point), 64'd2);
`endif

      // Opcode presented during UPDATE is dropped
      cycle(3'b001, 32'h100, 1'b1);
      cycle(3'b010, 32'h50, 1'b1);
      cycle(3'b000, '0, 1'b1);
      check_eq("update_ignore_addr", 64'(addr_point), 64'h100);

      // SJF +1 held for four edges executes twice (IDLE samples only)
      repeat (4) cycle(3'b010, 32'd1, 1'b1);
      cycle(3'b000, '0, 1'b1);
      check_eq("held_sjf_addr", 64'(addr_point), 64'h102);

      // Reset during UPDATE discards the pending target
      cycle(3'b001, 32'hABC, 1'b1);
      cycle(3'b000, '0, 1'b0);
      cycle(3'b000, '0, 1'b1);
      cycle(3'b000, '0, 1'b1);
      check_eq("rst_upd_addr", 64'(addr_point), 64'd0);
      check_eq("rst_upd_ready", 64'(ready), 64'd1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         op = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 2) == 0) op = ops[$urandom_range(1, 3)];
         case ($urandom_range(0, 3))
            0:       a = '0;
            1:       a = BW'($urandom_range(0, 15));
            2:       a = BW'($urandom);
            default: a = 32'hFFFF_FFF0 | BW'($urandom_range(0, 15));
         endcase
         rn = ($urandom_range(0, 99) != 0);
         cycle(op, a, rn);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
